// File: rtl/crc_gen_chk.sv
// ---------------------------------------------------------------------------
// crc_gen_chk - serial CRC generator / checker for the bit-serial packet path.
//
// Generate mode (mode=0): packet bits pass straight through with one clock of
// latency, then the CRC is appended MSB first, one bit every CLK_PER_BIT clocks.
// Check mode (mode=1): all bits pass through, and the trailing CRC_WIDTH bits
// are compared against the CRC of the payload. The first SKIP_BITS bits of
// every packet (preamble + access address) never touch the CRC.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   i_mode                 0 = generate/append, 1 = check (taken on first bit)
//   i_crc_init             LFSR initial value
//   i_crc_init_load        load i_crc_init (only honoured while idle)
//   i_info_bit             serial data bit
//   i_info_bit_valid       one-cycle strobe per input bit
//   i_info_bit_valid_last  with valid: final bit of the packet
//   o_out_bit              registered data / CRC bit
//   o_out_valid            one-cycle strobe per output bit
//   o_out_last             with o_out_valid: final output bit of the packet
//   o_crc_ok               check result, held until the next result
//   o_crc_ok_valid         one-cycle pulse when o_crc_ok updates
//   o_busy                 high whenever the FSM is not idle
//   o_dbg_state            current FSM state
//
// Strobe semantics: there is no backpressure. Every cycle with
// i_info_bit_valid high in IDLE or PASS carries exactly one bit and is
// consumed on that edge; strobes arriving in APPEND or CHECK are dropped.
// Output strobes are single-cycle and cannot be stalled.
// ---------------------------------------------------------------------------
module crc_gen_chk #(
  parameter int                   CRC_WIDTH   = 24,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY    = 24'h00065B,
  parameter int                   SKIP_BITS   = 40,
  parameter int                   CLK_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_mode,
  input  logic [CRC_WIDTH-1:0] i_crc_init,
  input  logic                 i_crc_init_load,
  input  logic                 i_info_bit,
  input  logic                 i_info_bit_valid,
  input  logic                 i_info_bit_valid_last,
  output logic                 o_out_bit,
  output logic                 o_out_valid,
  output logic                 o_out_last,
  output logic                 o_crc_ok,
  output logic                 o_crc_ok_valid,
  output logic                 o_busy,
  output logic [1:0]           o_dbg_state
);

  localparam int CLK_CNT_W = $clog2(CLK_PER_BIT);
  localparam int APP_CNT_W = $clog2(CRC_WIDTH);
  localparam int FILL_W    = $clog2(CRC_WIDTH + 1);

  localparam logic [CLK_CNT_W-1:0] CLK_LAST  = CLK_CNT_W'(CLK_PER_BIT - 1);
  localparam logic [APP_CNT_W-1:0] APP_LAST  = APP_CNT_W'(CRC_WIDTH - 1);
  localparam logic [FILL_W-1:0]    FILL_FULL = FILL_W'(CRC_WIDTH);
  localparam logic [8:0]           SKIP_L    = 9'(SKIP_BITS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PASS   = 2'd1,
    S_APPEND = 2'd2,
    S_CHECK  = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_mode;
  logic [8:0]             r_bit_cnt;   // saturates at SKIP_BITS
  logic [FILL_W-1:0]      r_fill;      // number of valid bits in the delay line
  logic [CRC_WIDTH-1:0]   r_lfsr;
  logic [CRC_WIDTH-1:0]   r_dline;     // check mode: last W post-skip bits, oldest at MSB
  logic [CLK_CNT_W-1:0]   r_clk_cnt;
  logic [APP_CNT_W-1:0]   r_app_cnt;
  logic                   r_out_bit;
  logic                   r_out_valid;
  logic                   r_out_last;
  logic                   r_crc_ok;
  logic                   r_crc_ok_valid;

  logic                   w_accept;
  logic                   w_mode_cur;
  logic                   w_app_tick;
  logic [8:0]             w_bit_idx;
  logic [FILL_W-1:0]      w_fill_cur;
  logic [CRC_WIDTH-1:0]   w_lfsr_base;
  logic                   w_post_skip;
  logic                   w_dline_full;
  logic                   w_feed;
  logic                   w_feed_en;
  logic [CRC_WIDTH-1:0]   w_lfsr_nxt;
  logic [APP_CNT_W-1:0]   w_app_idx;

  function automatic logic [CRC_WIDTH-1:0] lfsr_step(input logic [CRC_WIDTH-1:0] s,
                                                     input logic d);
    logic fb;
    fb = s[CRC_WIDTH-1] ^ d;
    return {s[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the per-packet view of mode / counters. In IDLE the
  // incoming bit is the first of a new packet, so counters read as zero and a
  // simultaneous load becomes the LFSR starting point for that same bit.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_app_tick  = 1'b0;
    w_mode_cur  = r_mode;
    w_bit_idx   = r_bit_cnt;
    w_fill_cur  = r_fill;
    w_lfsr_base = r_lfsr;
    case (r_state)
      S_IDLE: begin
        w_mode_cur = i_mode;
        w_bit_idx  = '0;
        w_fill_cur = '0;
        if (i_crc_init_load) w_lfsr_base = i_crc_init;
        if (i_info_bit_valid) begin
          w_accept = 1'b1;
          if (i_info_bit_valid_last) w_state_nxt = i_mode ? S_CHECK : S_APPEND;
          else                       w_state_nxt = S_PASS;
        end
      end
      S_PASS: begin
        if (i_info_bit_valid) begin
          w_accept = 1'b1;
          if (i_info_bit_valid_last) w_state_nxt = r_mode ? S_CHECK : S_APPEND;
        end
      end
      S_APPEND: begin
        if (r_clk_cnt == CLK_LAST) begin
          w_app_tick = 1'b1;
          if (r_app_cnt == APP_LAST) w_state_nxt = S_IDLE;
        end
      end
      S_CHECK: begin
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Generate mode feeds every post-skip bit to the LFSR. Check mode feeds only
  // the bit falling out of the full delay line, so the trailing W bits (the
  // received CRC) stay out of the computation.
  assign w_post_skip  = (w_bit_idx >= SKIP_L);
  assign w_dline_full = (w_fill_cur == FILL_FULL);
  assign w_feed       = w_mode_cur ? r_dline[CRC_WIDTH-1] : i_info_bit;
  assign w_feed_en    = w_accept && w_post_skip && (!w_mode_cur || w_dline_full);
  assign w_lfsr_nxt   = w_feed_en ? lfsr_step(w_lfsr_base, w_feed) : w_lfsr_base;
  assign w_app_idx    = APP_LAST - r_app_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode         <= 1'b0;
      r_bit_cnt      <= '0;
      r_fill         <= '0;
      r_lfsr         <= '0;
      r_dline        <= '0;
      r_clk_cnt      <= '0;
      r_app_cnt      <= '0;
      r_out_bit      <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_last     <= 1'b0;
      r_crc_ok       <= 1'b0;
      r_crc_ok_valid <= 1'b0;
    end else begin
      r_out_valid    <= 1'b0;
      r_out_last     <= 1'b0;
      r_crc_ok_valid <= 1'b0;
      r_lfsr         <= w_lfsr_nxt;

      if (w_accept) begin
        r_mode      <= w_mode_cur;
        r_out_bit   <= i_info_bit;
        r_out_valid <= 1'b1;
        // In generate mode the final appended bit carries out_last instead.
        r_out_last  <= i_info_bit_valid_last & w_mode_cur;
        r_bit_cnt   <= w_post_skip ? w_bit_idx : w_bit_idx + 9'd1;
        r_fill      <= w_fill_cur;
        if (w_post_skip && w_mode_cur) begin
          r_dline <= {r_dline[CRC_WIDTH-2:0], i_info_bit};
          if (!w_dline_full) r_fill <= w_fill_cur + FILL_W'(1);
        end
        if (i_info_bit_valid_last) begin
          r_clk_cnt <= '0;
          r_app_cnt <= '0;
        end
      end

      // LFSR is frozen here; bits are read out by index, MSB first.
      if (r_state == S_APPEND) begin
        if (w_app_tick) begin
          r_clk_cnt   <= '0;
          r_out_bit   <= r_lfsr[w_app_idx];
          r_out_valid <= 1'b1;
          r_out_last  <= (r_app_cnt == APP_LAST);
          r_app_cnt   <= r_app_cnt + APP_CNT_W'(1);
        end else begin
          r_clk_cnt   <= r_clk_cnt + CLK_CNT_W'(1);
        end
      end

      // A packet too short to fill the delay line can never pass.
      if (r_state == S_CHECK) begin
        r_crc_ok       <= (r_fill == FILL_FULL) && (r_dline == r_lfsr);
        r_crc_ok_valid <= 1'b1;
      end
    end
  end

  assign o_out_bit      = r_out_bit;
  assign o_out_valid    = r_out_valid;
  assign o_out_last     = r_out_last;
  assign o_crc_ok       = r_crc_ok;
  assign o_crc_ok_valid = r_crc_ok_valid;
  assign o_busy         = (r_state != S_IDLE);
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_crc_gen_chk.sv
module tb_crc_gen_chk;

  localparam int              W    = 24;
  localparam int              SKIP = 40;
  localparam int              CPB  = 16;
  localparam logic [W-1:0]    POLY = 24'h00065B;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         mode = 1'b0;
  logic [W-1:0] crc_init = '0;
  logic         crc_init_load = 1'b0;
  logic         info_bit = 1'b0;
  logic         info_bit_valid = 1'b0;
  logic         info_bit_valid_last = 1'b0;
  logic         o_out_bit, o_out_valid, o_out_last, o_crc_ok, o_crc_ok_valid, o_busy;
  logic [1:0]   o_dbg_state;

  crc_gen_chk #(
    .CRC_WIDTH  (W),
    .CRC_POLY   (POLY),
    .SKIP_BITS  (SKIP),
    .CLK_PER_BIT(CPB)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_mode               (mode),
    .i_crc_init           (crc_init),
    .i_crc_init_load      (crc_init_load),
    .i_info_bit           (info_bit),
    .i_info_bit_valid     (info_bit_valid),
    .i_info_bit_valid_last(info_bit_valid_last),
    .o_out_bit            (o_out_bit),
    .o_out_valid          (o_out_valid),
    .o_out_last           (o_out_last),
    .o_crc_ok             (o_crc_ok),
    .o_crc_ok_valid       (o_crc_ok_valid),
    .o_busy               (o_busy),
    .o_dbg_state          (o_dbg_state)
  );

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  // exp_q entry: {busy after the edge, out_last, out_bit}
  logic [2:0] exp_q[$];
  int         exp_cyc_q[$];
  logic       ok_q[$];
  int         ok_cyc_q[$];

  logic [2:0] mon_e;
  int         mon_c;
  logic       mon_ok;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_out_valid) begin
        chk("out_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          mon_c = exp_cyc_q.pop_front();
          chk("out_bit", 32'(o_out_bit), 32'(mon_e[0]));
          chk("out_last", 32'(o_out_last), 32'(mon_e[1]));
          chk("busy_at_out", 32'(o_busy), 32'(mon_e[2]));
          chk("out_cycle", 32'(cyc), 32'(mon_c));
        end
      end
      if (o_crc_ok_valid) begin
        chk("ok_expected", 32'(ok_q.size() > 0), 32'd1);
        if (ok_q.size() > 0) begin
          mon_ok = ok_q.pop_front();
          mon_c  = ok_cyc_q.pop_front();
          chk("crc_ok", 32'(o_crc_ok), 32'(mon_ok));
          chk("ok_cycle", 32'(cyc), 32'(mon_c));
          chk("busy_at_ok", 32'(o_busy), 32'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic pkt_q[$];

  task automatic add_skip();
    for (int i = 0; i < SKIP; i++) pkt_q.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic add_vec(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) pkt_q.push_back(v[i]);
  endtask

  function automatic logic [W-1:0] ref_crc(input logic [W-1:0] init, input logic [63:0] pay,
                                           input int n);
    logic [W-1:0] c;
    logic         fb;
    c = init;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[W-1] ^ pay[i];
      c  = {c[W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  task automatic drive_bit(input logic b, input logic last, input logic ld,
                           input logic [W-1:0] init_v, input logic [2:0] exp_v);
    @(negedge clk);
    info_bit            = b;
    info_bit_valid      = 1'b1;
    info_bit_valid_last = last;
    crc_init_load       = ld;
    crc_init            = init_v;
    exp_q.push_back(exp_v);
    exp_cyc_q.push_back(cyc + 1);
    @(negedge clk);
    info_bit_valid      = 1'b0;
    info_bit_valid_last = 1'b0;
    crc_init_load       = 1'b0;
  endtask

  // Sends pkt_q. Init is loaded with the first bit; a stray load of 0xABCDEF
  // is raised on bit stray_at (must be ignored). t_last = edge sampling last bit.
  task automatic send_pkt(input logic m, input logic [W-1:0] init_v, input int stray_at,
                          input logic [W-1:0] exp_crc, input logic exp_ok, output int t_last);
    int           n;
    logic         last;
    logic         ld;
    logic [W-1:0] iv;
    n    = pkt_q.size();
    mode = m;
    for (int j = 0; j < n; j++) begin
      last = (j == n - 1);
      ld   = (j == 0) || (j == stray_at);
      iv   = (j == 0) ? init_v : 24'hABCDEF;
      drive_bit(pkt_q[j], last, ld, iv, {1'b1, last & m, pkt_q[j]});
      if (j == 0) chk("busy_rise", 32'(o_busy), 32'd1);
    end
    t_last = cyc;
    if (!m) begin
      for (int k = 0; k < W; k++) begin
        exp_q.push_back({(k != W - 1), (k == W - 1), exp_crc[W-1-k]});
        exp_cyc_q.push_back(t_last + (k + 1) * CPB);
      end
    end else begin
      ok_q.push_back(exp_ok);
      ok_cyc_q.push_back(t_last + 1);
    end
    pkt_q.delete();
  endtask

  task automatic wait_done();
    int budget;
    budget = 3000;
    while (o_busy && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("done_in_time", 32'(budget > 0), 32'd1);
    repeat (3) @(negedge clk);
    chk("outs_drained", 32'(exp_q.size()), 32'd0);
    chk("oks_drained", 32'(ok_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int           t;
  logic [63:0]  pay;
  logic [W-1:0] crc;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_bit", 32'(o_out_bit), 32'd0);
    chk("rst_out_valid", 32'(o_out_valid), 32'd0);
    chk("rst_out_last", 32'(o_out_last), 32'd0);
    chk("rst_crc_ok", 32'(o_crc_ok), 32'd0);
    chk("rst_crc_ok_valid", 32'(o_crc_ok_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_state", 32'(o_dbg_state), 32'd0);
    rst = 1'b0;

    // Generate, init 0, 16 zero payload bits -> CRC 0
    add_skip(); add_vec(64'h0, 16);
    send_pkt(1'b0, 24'h000000, -1, 24'h000000, 1'b0, t); wait_done();

    // Generate, init 0x555555, empty payload -> 0x555555 appended
    add_skip();
    send_pkt(1'b0, 24'h555555, -1, 24'h555555, 1'b0, t); wait_done();

    // Generate, init 0, payload "10": one step gives POLY, a zero shifts it -> 0x000CB6.
    // Stray load on the second payload bit must be ignored.
    add_skip(); add_vec(64'h2, 2);
    send_pkt(1'b0, 24'h000000, 41, 24'h000CB6, 1'b0, t); wait_done();

    // Generate, last before skip completes -> LFSR as loaded
    add_vec(64'h2C9, 10);
    send_pkt(1'b0, 24'h0F0F0F, -1, 24'h0F0F0F, 1'b0, t); wait_done();

    // Loopback: generate then check with same init; stray load in skip region
    pay = {$urandom(), $urandom()};
    crc = ref_crc(24'hA5A5A5, pay, 64);
    add_skip(); add_vec(pay, 64);
    send_pkt(1'b0, 24'hA5A5A5, -1, crc, 1'b0, t); wait_done();
    add_skip(); add_vec(pay, 64); add_vec({40'h0, crc}, W);
    send_pkt(1'b1, 24'hA5A5A5, 20, '0, 1'b1, t); wait_done();
    repeat (5) @(negedge clk);
    chk("ok_held", 32'(o_crc_ok), 32'd1);

    // Flipped payload bit
    add_skip(); add_vec(pay ^ 64'h0000_0000_0002_0000, 64); add_vec({40'h0, crc}, W);
    send_pkt(1'b1, 24'hA5A5A5, -1, '0, 1'b0, t); wait_done();

    // Flipped CRC bit
    add_skip(); add_vec(pay, 64); add_vec({40'h0, crc ^ 24'h000008}, W);
    send_pkt(1'b1, 24'hA5A5A5, -1, '0, 1'b0, t); wait_done();

    // Check, exactly SKIP+W bits: empty payload, CRC equals init -> ok
    add_skip(); add_vec(64'h123456, W);
    send_pkt(1'b1, 24'h123456, -1, '0, 1'b1, t); wait_done();

    // Check, 40+10 bits: too short -> ok=0 still pulses
    add_skip(); add_vec(64'h155, 10);
    send_pkt(1'b1, 24'h123456, -1, '0, 1'b0, t); wait_done();

    // Reset during appended bit 5 (k=5, a '1' of 0x555555)
    add_skip();
    send_pkt(1'b0, 24'h555555, -1, 24'h555555, 1'b0, t);
    while (cyc < t + 6 * CPB) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(o_out_valid), 32'd0);
    chk("arst_out_bit", 32'(o_out_bit), 32'd0);
    chk("arst_busy", 32'(o_busy), 32'd0);
    chk("arst_state", 32'(o_dbg_state), 32'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    // Fresh packet after the abort
    add_skip();
    send_pkt(1'b0, 24'h555555, -1, 24'h555555, 1'b0, t); wait_done();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
